// File: rtl/umi_reg_if.sv
// umi_reg_if: UMI device request -> single register read/write bridge with UMI response
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   udev_req_*                    UMI request in (valid/ready, cmd, dstaddr, srcaddr, data)
//   udev_resp_*                   UMI response out (valid/ready, cmd, dstaddr, srcaddr, data)
//   reg_write/reg_read            register access strobes, held until reg_ready
//   reg_addr/reg_wrdata           captured address and low RW bits of write data
//   reg_opcode/size/len/prot      captured request command fields
//   reg_rddata/reg_ready/reg_err  register read data, completion, error code
module umi_reg_if #(
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 256,
    parameter int RW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          udev_req_valid,
    input  logic [CW-1:0] udev_req_cmd,
    input  logic [AW-1:0] udev_req_dstaddr,
    input  logic [AW-1:0] udev_req_srcaddr,
    input  logic [DW-1:0] udev_req_data,
    output logic          udev_req_ready,
    output logic          udev_resp_valid,
    output logic [CW-1:0] udev_resp_cmd,
    output logic [AW-1:0] udev_resp_dstaddr,
    output logic [AW-1:0] udev_resp_srcaddr,
    output logic [DW-1:0] udev_resp_data,
    input  logic          udev_resp_ready,
    output logic          reg_write,
    output logic          reg_read,
    output logic [AW-1:0] reg_addr,
    output logic [RW-1:0] reg_wrdata,
    output logic [4:0]    reg_opcode,
    output logic [2:0]    reg_size,
    output logic [7:0]    reg_len,
    output logic [1:0]    reg_prot,
    input  logic [RW-1:0] reg_rddata,
    input  logic          reg_ready,
    input  logic [1:0]    reg_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(RW / 8));
    state_t        state, state_nx;
    logic [CW-1:0] cmd_q;
    logic [AW-1:0] dst_q, src_q;
    logic [RW-1:0] wr_q, rd_q;
    logic [1:0]    err_q;
    logic          req_fire, req_known, is_read, is_posted, bad_shape;
    logic          unused;
    assign unused = ^udev_req_data;
    assign req_fire = udev_req_valid & udev_req_ready;
    assign req_known = udev_req_cmd[4:0] == 5'h01 || udev_req_cmd[4:0] == 5'h03 || udev_req_cmd[4:0] == 5'h05;
    assign is_read = cmd_q[4:0] == 5'h01;
    assign is_posted = cmd_q[4:0] == 5'h05;
    // Multi-beat or over-wide accesses still perform one access but report an error.
    assign bad_shape = cmd_q[15:8] != 8'd0 || cmd_q[7:5] > MAX_SIZE;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req_fire) state_nx = req_known ? ACCESS : RESP;
            ACCESS:  if (reg_ready) state_nx = is_posted ? IDLE : RESP;
            RESP:    if (udev_resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q <= '0;
            dst_q <= '0;
            src_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            err_q <= '0;
        end else if (req_fire) begin
            cmd_q <= udev_req_cmd;
            dst_q <= udev_req_dstaddr;
            src_q <= udev_req_srcaddr;
            wr_q  <= udev_req_data[RW-1:0];
            rd_q  <= '0;
            err_q <= req_known ? 2'b00 : 2'b10;
        end else if (state == ACCESS && reg_ready) begin
            err_q <= bad_shape ? 2'b10 : reg_err;
            if (is_read) rd_q <= reg_rddata;
        end
    end
    // Gated with rst so nothing is offered while reset is held.
    assign udev_req_ready = state == IDLE && !rst;
    assign udev_resp_valid = state == RESP;
    assign udev_resp_dstaddr = src_q;
    assign udev_resp_srcaddr = dst_q;
    assign udev_resp_data = DW'(rd_q);
    always_comb begin
        udev_resp_cmd = cmd_q;
        udev_resp_cmd[4:0] = is_read ? 5'h02 : 5'h04;
        udev_resp_cmd[26:25] = err_q;
    end
    assign reg_read = state == ACCESS && is_read;
    assign reg_write = state == ACCESS && !is_read;
    assign reg_addr = dst_q;
    assign reg_wrdata = wr_q;
    assign reg_opcode = cmd_q[4:0];
    assign reg_size = cmd_q[7:5];
    assign reg_len = cmd_q[15:8];
    assign reg_prot = cmd_q[21:20];
endmodule

// File: tb/tb_umi_reg_if.sv
// tb_umi_reg_if: randomized self-checking bench for umi_reg_if against a transaction-level model
module tb_umi_reg_if;
    logic         clk = 0, rst = 1;
    logic         udev_req_valid = 0, udev_req_ready, udev_resp_valid, udev_resp_ready = 0;
    logic [31:0]  udev_req_cmd = 0, udev_resp_cmd;
    logic [63:0]  udev_req_dstaddr = 0, udev_req_srcaddr = 0, udev_resp_dstaddr, udev_resp_srcaddr;
    logic [255:0] udev_req_data = 0, udev_resp_data;
    logic         reg_write, reg_read, reg_ready = 0;
    logic [63:0]  reg_addr;
    logic [31:0]  reg_wrdata, reg_rddata = 0;
    logic [4:0]   reg_opcode;
    logic [2:0]   reg_size;
    logic [7:0]   reg_len;
    logic [1:0]   reg_prot, reg_err = 0;
    int errors = 0, checks = 0;
    logic [31:0] dev_mem [logic [63:0]];
    logic [31:0] exp_mem [logic [63:0]];

    typedef struct {
        int n_strobe; int resp_lat; logic saw_rd; logic saw_wr;
        logic [63:0] s_addr; logic [31:0] s_wdata; logic [17:0] s_fields;
        logic resp_seen; logic [31:0] r_cmd; logic [63:0] r_dst; logic [63:0] r_src;
        logic [255:0] r_data; logic r_stable; logic idle_after;
    } obs_t;
    typedef struct {
        int n_strobe; logic rd; logic wr; logic resp; logic [31:0] cmd; logic [255:0] data;
    } exp_t;

    umi_reg_if dut (
        .clk(clk), .rst(rst),
        .udev_req_valid(udev_req_valid), .udev_req_cmd(udev_req_cmd),
        .udev_req_dstaddr(udev_req_dstaddr), .udev_req_srcaddr(udev_req_srcaddr),
        .udev_req_data(udev_req_data), .udev_req_ready(udev_req_ready),
        .udev_resp_valid(udev_resp_valid), .udev_resp_cmd(udev_resp_cmd),
        .udev_resp_dstaddr(udev_resp_dstaddr), .udev_resp_srcaddr(udev_resp_srcaddr),
        .udev_resp_data(udev_resp_data), .udev_resp_ready(udev_resp_ready),
        .reg_write(reg_write), .reg_read(reg_read), .reg_addr(reg_addr), .reg_wrdata(reg_wrdata),
        .reg_opcode(reg_opcode), .reg_size(reg_size), .reg_len(reg_len), .reg_prot(reg_prot),
        .reg_rddata(reg_rddata), .reg_ready(reg_ready), .reg_err(reg_err)
    );

    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_cmd(input logic [4:0] op, input logic [2:0] size, input logic [7:0] len, input logic [1:0] prot);
        return {5'd0, 2'd0, 3'd0, prot, 4'd0, len, size, op};
    endfunction

    // Transaction-level reference: what a single request must produce.
    function automatic exp_t model(input logic [31:0] cmd, input logic [63:0] dst, input logic [255:0] data, input int waits, input logic [1:0] rerr);
        exp_t e;
        logic known;
        logic [1:0] err;
        known = cmd[4:0] == 5'h01 || cmd[4:0] == 5'h03 || cmd[4:0] == 5'h05;
        e.rd = cmd[4:0] == 5'h01;
        e.wr = cmd[4:0] == 5'h03 || cmd[4:0] == 5'h05;
        e.resp = cmd[4:0] != 5'h05;
        e.n_strobe = known ? waits + 1 : 0;
        err = (known && cmd[15:8] == 0 && cmd[7:5] <= 2) ? rerr : 2'b10;
        e.cmd = (cmd & ~32'h0600_001F) | (32'(err) << 25) | (e.rd ? 32'h2 : 32'h4);
        e.data = e.rd ? 256'(exp_mem.exists(dst) ? exp_mem[dst] : 32'h0) : 256'h0;
        if (e.wr) exp_mem[dst] = data[31:0];
        return e;
    endfunction

    // Drives one request, plays the register slave, consumes the response; records what was seen.
    task automatic run_txn(input logic [31:0] cmd, input logic [63:0] dst, input logic [63:0] src, input logic [255:0] data,
                           input int waits, input logic [1:0] rerr, input int stall, output obs_t o);
        int cyc;
        o = '{default: 0};
        o.r_stable = 1;
        udev_req_valid = 1; udev_req_cmd = cmd; udev_req_dstaddr = dst; udev_req_srcaddr = src; udev_req_data = data;
        @(negedge clk);
        udev_req_valid = 0; udev_req_data = {8{$urandom}};
        for (cyc = 0; cyc < 64; cyc++) begin
            if (!(reg_read || reg_write)) break;
            if (o.n_strobe == 0) begin
                o.s_addr = reg_addr; o.s_wdata = reg_wrdata; o.s_fields = {reg_prot, reg_len, reg_size, reg_opcode};
            end
            o.saw_rd |= reg_read; o.saw_wr |= reg_write;
            o.n_strobe++;
            reg_ready = o.n_strobe > waits;
            reg_err = reg_ready ? rerr : 2'($urandom);
            reg_rddata = reg_ready ? (dev_mem.exists(reg_addr) ? dev_mem[reg_addr] : 32'h0) : $urandom;
            if (reg_write && reg_ready) dev_mem[reg_addr] = reg_wrdata;
            @(negedge clk);
        end
        reg_ready = 0; reg_err = 2'($urandom); reg_rddata = $urandom;
        o.resp_lat = cyc;
        o.resp_seen = udev_resp_valid;
        if (o.resp_seen) begin
            o.r_cmd = udev_resp_cmd; o.r_dst = udev_resp_dstaddr; o.r_src = udev_resp_srcaddr; o.r_data = udev_resp_data;
            if (udev_req_ready) o.r_stable = 0;
            repeat (stall) begin
                @(negedge clk);
                if (udev_resp_cmd !== o.r_cmd || udev_resp_dstaddr !== o.r_dst || udev_resp_srcaddr !== o.r_src ||
                    udev_resp_data !== o.r_data || !udev_resp_valid || udev_req_ready || reg_read || reg_write) o.r_stable = 0;
            end
            udev_resp_ready = 1;
            @(negedge clk);
            udev_resp_ready = 0;
        end
        o.idle_after = udev_req_ready && !udev_resp_valid;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (udev_req_ready !== 0) begin errors++; $display("FAIL rst_req_ready got=%b exp=0", udev_req_ready); end
        checks++; if (udev_resp_valid !== 0) begin errors++; $display("FAIL rst_resp_valid got=%b exp=0", udev_resp_valid); end
        checks++; if ({reg_read, reg_write} !== 2'b00) begin errors++; $display("FAIL rst_strobes got=%b exp=00", {reg_read, reg_write}); end
        checks++; if (reg_addr !== 0 || reg_wrdata !== 0) begin errors++; $display("FAIL rst_regbus got=%h/%h exp=0", reg_addr, reg_wrdata); end
        rst = 0;
        @(negedge clk);
        checks++; if (udev_req_ready !== 1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", udev_req_ready); end
    endtask

    task automatic test_write;
        obs_t o; exp_t e; logic [31:0] c;
        c = mk_cmd(5'h03, 3'd2, 8'd0, 2'd0);
        e = model(c, 64'h10, 256'hDEADBEEF, 0, 2'b00);
        run_txn(c, 64'h10, 64'h8000, 256'hDEADBEEF, 0, 2'b00, 0, o);
        checks++; if (o.n_strobe !== 1 || !o.saw_wr || o.saw_rd) begin errors++; $display("FAIL write_strobe got=%0d rd=%b wr=%b exp=1 wr", o.n_strobe, o.saw_rd, o.saw_wr); end
        checks++; if (o.s_addr !== 64'h10 || o.s_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL write_bus got=%h/%h exp=10/deadbeef", o.s_addr, o.s_wdata); end
        checks++; if (o.resp_lat !== 1) begin errors++; $display("FAIL write_latency got=%0d exp=1", o.resp_lat); end
        checks++; if (!o.resp_seen || o.r_cmd !== e.cmd) begin errors++; $display("FAIL write_resp_cmd got=%h seen=%b exp=%h", o.r_cmd, o.resp_seen, e.cmd); end
        checks++; if (o.r_dst !== 64'h8000 || o.r_src !== 64'h10) begin errors++; $display("FAIL write_resp_addr got=%h/%h exp=8000/10", o.r_dst, o.r_src); end
        checks++; if (!o.idle_after) begin errors++; $display("FAIL write_idle got=0 exp=1"); end
    endtask

    task automatic test_read;
        obs_t o; exp_t e; logic [31:0] c;
        c = mk_cmd(5'h01, 3'd2, 8'd0, 2'd1);
        e = model(c, 64'h10, 256'h0, 0, 2'b00);
        run_txn(c, 64'h10, 64'h9000, 256'h0, 0, 2'b00, 0, o);
        checks++; if (o.n_strobe !== 1 || !o.saw_rd || o.saw_wr) begin errors++; $display("FAIL read_strobe got=%0d rd=%b wr=%b exp=1 rd", o.n_strobe, o.saw_rd, o.saw_wr); end
        checks++; if (o.s_fields !== {c[21:20], c[15:8], c[7:5], c[4:0]}) begin errors++; $display("FAIL read_fields got=%h exp=%h", o.s_fields, {c[21:20], c[15:8], c[7:5], c[4:0]}); end
        checks++; if (o.r_cmd !== e.cmd) begin errors++; $display("FAIL read_resp_cmd got=%h exp=%h", o.r_cmd, e.cmd); end
        checks++; if (o.r_data !== e.data) begin errors++; $display("FAIL read_data got=%h exp=%h", o.r_data, e.data); end
    endtask

    task automatic test_posted;
        obs_t o; exp_t e; logic [31:0] c;
        c = mk_cmd(5'h05, 3'd2, 8'd0, 2'd0);
        e = model(c, 64'h20, 256'h1234, 0, 2'b00);
        run_txn(c, 64'h20, 64'h8000, 256'h1234, 0, 2'b00, 0, o);
        checks++; if (o.n_strobe !== e.n_strobe || !o.saw_wr) begin errors++; $display("FAIL posted_strobe got=%0d exp=%0d", o.n_strobe, e.n_strobe); end
        checks++; if (o.resp_seen !== 0) begin errors++; $display("FAIL posted_resp got=%b exp=0", o.resp_seen); end
        checks++; if (!o.idle_after) begin errors++; $display("FAIL posted_ready got=0 exp=1"); end
        c = mk_cmd(5'h01, 3'd2, 8'd0, 2'd0);
        e = model(c, 64'h20, 256'h0, 0, 2'b00);
        run_txn(c, 64'h20, 64'h8100, 256'h0, 0, 2'b00, 0, o);
        checks++; if (!o.resp_seen || o.r_data !== e.data) begin errors++; $display("FAIL posted_readback got=%h exp=%h", o.r_data, e.data); end
    endtask

    task automatic test_back_pressure;
        obs_t o; exp_t e; logic [31:0] c;
        c = mk_cmd(5'h01, 3'd1, 8'd0, 2'd3);
        e = model(c, 64'h10, 256'h0, 0, 2'b00);
        run_txn(c, 64'h10, 64'hA000, 256'h0, 0, 2'b00, 5, o);
        checks++; if (!o.resp_seen || !o.r_stable) begin errors++; $display("FAIL stall_stable got=%b exp=1", o.r_stable); end
        checks++; if (o.r_cmd !== e.cmd || o.r_data !== e.data) begin errors++; $display("FAIL stall_resp got=%h exp=%h", o.r_cmd, e.cmd); end
        checks++; if (!o.idle_after) begin errors++; $display("FAIL stall_idle got=0 exp=1"); end
    endtask

    task automatic test_reg_wait;
        obs_t o; exp_t e; logic [31:0] c;
        c = mk_cmd(5'h03, 3'd2, 8'd0, 2'd0);
        e = model(c, 64'h30, 256'hCAFE, 3, 2'b10);
        run_txn(c, 64'h30, 64'h8000, 256'hCAFE, 3, 2'b10, 0, o);
        checks++; if (o.n_strobe !== 4) begin errors++; $display("FAIL wait_strobe got=%0d exp=4", o.n_strobe); end
        checks++; if (o.r_cmd !== e.cmd) begin errors++; $display("FAIL wait_err got=%h exp=%h", o.r_cmd, e.cmd); end
        c = mk_cmd(5'h01, 3'd2, 8'd0, 2'd0);
        e = model(c, 64'h30, 256'h0, 2, 2'b01);
        run_txn(c, 64'h30, 64'h8000, 256'h0, 2, 2'b01, 0, o);
        checks++; if (o.n_strobe !== 3 || o.r_data !== e.data || o.r_cmd !== e.cmd) begin errors++; $display("FAIL wait_read got=%0d %h %h exp=3 %h %h", o.n_strobe, o.r_data, o.r_cmd, e.data, e.cmd); end
    endtask

    task automatic test_bad_cmd;
        obs_t o; exp_t e; logic [31:0] c;
        c = mk_cmd(5'h07, 3'd2, 8'd0, 2'd0);
        e = model(c, 64'h40, 256'h0, 0, 2'b00);
        run_txn(c, 64'h40, 64'h8000, 256'h0, 0, 2'b00, 0, o);
        checks++; if (o.n_strobe !== 0 || o.resp_lat !== 0) begin errors++; $display("FAIL badop_strobe got=%0d lat=%0d exp=0 0", o.n_strobe, o.resp_lat); end
        checks++; if (!o.resp_seen || o.r_cmd !== e.cmd) begin errors++; $display("FAIL badop_resp got=%h exp=%h", o.r_cmd, e.cmd); end
        c = mk_cmd(5'h03, 3'd2, 8'd3, 2'd0);
        e = model(c, 64'h48, 256'h55, 0, 2'b00);
        run_txn(c, 64'h48, 64'h8000, 256'h55, 0, 2'b00, 0, o);
        checks++; if (o.n_strobe !== 1 || o.r_cmd !== e.cmd) begin errors++; $display("FAIL multibeat got=%0d %h exp=1 %h", o.n_strobe, o.r_cmd, e.cmd); end
        c = mk_cmd(5'h01, 3'd3, 8'd0, 2'd0);
        e = model(c, 64'h48, 256'h0, 0, 2'b00);
        run_txn(c, 64'h48, 64'h8000, 256'h0, 0, 2'b00, 0, o);
        checks++; if (o.n_strobe !== 1 || o.r_cmd !== e.cmd || o.r_data !== e.data) begin errors++; $display("FAIL oversize got=%0d %h exp=1 %h", o.n_strobe, o.r_cmd, e.cmd); end
    endtask

    task automatic test_reset_mid;
        udev_req_valid = 1; udev_req_cmd = mk_cmd(5'h01, 3'd2, 8'd0, 2'd0); udev_req_dstaddr = 64'h10;
        @(negedge clk);
        udev_req_valid = 0; reg_ready = 1;
        @(negedge clk);
        reg_ready = 0;
        checks++; if (udev_resp_valid !== 1) begin errors++; $display("FAIL midrst_pre got=%b exp=1", udev_resp_valid); end
        rst = 1;
        @(negedge clk);
        checks++; if (udev_resp_valid !== 0 || udev_req_ready !== 0) begin errors++; $display("FAIL midrst_drop got=%b/%b exp=0/0", udev_resp_valid, udev_req_ready); end
        rst = 0;
        @(negedge clk);
        checks++; if (udev_req_ready !== 1 || udev_resp_valid !== 0) begin errors++; $display("FAIL midrst_release got=%b/%b exp=1/0", udev_req_ready, udev_resp_valid); end
    endtask

    task automatic test_random;
        obs_t o; exp_t e; logic [31:0] c; logic [63:0] dst, src; logic [255:0] d; int w, st; logic [1:0] re;
        logic [4:0] ops [6];
        ops = '{5'h01, 5'h03, 5'h05, 5'h01, 5'h03, 5'h00};
        for (int i = 0; i < 200; i++) begin
            c = $urandom;
            c[4:0] = ops[$urandom_range(0, 5)];
            if (c[4:0] == 5'h00) c[4:0] = 5'($urandom);
            if ($urandom_range(0, 3) != 0) c[15:8] = 8'd0;
            if ($urandom_range(0, 3) != 0) c[7:5] = 3'($urandom_range(0, 2));
            dst = 64'($urandom_range(0, 7)) << 2;
            src = {$urandom, $urandom};
            d = {8{$urandom}};
            w = $urandom_range(0, 3); re = 2'($urandom); st = $urandom_range(0, 2);
            e = model(c, dst, d, w, re);
            run_txn(c, dst, src, d, w, re, st, o);
            checks++; if (o.n_strobe !== e.n_strobe || o.saw_rd !== e.rd || o.saw_wr !== e.wr) begin errors++; $display("FAIL rnd%0d_strobe got=%0d rd=%b wr=%b exp=%0d rd=%b wr=%b", i, o.n_strobe, o.saw_rd, o.saw_wr, e.n_strobe, e.rd, e.wr); end
            checks++; if (o.resp_seen !== e.resp) begin errors++; $display("FAIL rnd%0d_resp got=%b exp=%b", i, o.resp_seen, e.resp); end
            if (e.rd || e.wr) begin
                checks++; if (o.s_addr !== dst || o.s_fields !== {c[21:20], c[15:8], c[7:5], c[4:0]}) begin errors++; $display("FAIL rnd%0d_bus got=%h/%h exp=%h/%h", i, o.s_addr, o.s_fields, dst, {c[21:20], c[15:8], c[7:5], c[4:0]}); end
            end
            if (e.wr) begin
                checks++; if (o.s_wdata !== d[31:0]) begin errors++; $display("FAIL rnd%0d_wdata got=%h exp=%h", i, o.s_wdata, d[31:0]); end
            end
            if (e.resp && o.resp_seen) begin
                checks++; if (o.r_cmd !== e.cmd || o.r_dst !== src || o.r_src !== dst || !o.r_stable) begin errors++; $display("FAIL rnd%0d_rsp got=%h %h %h st=%b exp=%h %h %h", i, o.r_cmd, o.r_dst, o.r_src, o.r_stable, e.cmd, src, dst); end
                if (e.rd) begin
                    checks++; if (o.r_data !== e.data) begin errors++; $display("FAIL rnd%0d_rdata got=%h exp=%h", i, o.r_data, e.data); end
                end
            end
            checks++; if (!o.idle_after) begin errors++; $display("FAIL rnd%0d_idle got=0 exp=1", i); end
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_posted;
        test_back_pressure;
        test_reg_wait;
        test_bad_cmd;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
